// File: rtl/controlador_sequenciador.sv
// SAP-1 control sequencer: one-hot six-state ring counter plus microcode decode of the IR opcode.
// Drives every datapath load/enable line, including su/eu of the adder/subtractor.
module controlador_sequenciador #(
   parameter bit SKIP_IDLE = 1'b0
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] opcode,
   output logic [5:0] t_state,
   output logic       cp,
   output logic       ep,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb,
   output logic       lo,
   output logic       hlt
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_t;

   ring_t state_p0, state_nxt;
   logic  halted_p0, halted_nxt;

   logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

   assign is_lda = (opcode == 4'b0000);
   assign is_add = (opcode == 4'b0001);
   assign is_sub = (opcode == 4'b0010);
   assign is_out = (opcode == 4'b1110);
   assign is_hlt = (opcode == 4'b1111);
   assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

   // stage p0: ring state and halt flag
   always_ff @(posedge clk) begin
      if (clr) begin
         state_p0  <= T1;
         halted_p0 <= 1'b0;
      end else begin
         state_p0  <= state_nxt;
         halted_p0 <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = T1;
      halted_nxt = halted_p0;
      if (halted_p0) begin
         state_nxt = state_p0;
      end else begin
         case (state_p0)
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            // NOP still needs T3->T4 so the opcode is latched before it can be judged
            T3: state_nxt = T4;
            T4: begin
               if (is_hlt) begin
                  state_nxt  = T4;
                  halted_nxt = 1'b1;
               end else if (SKIP_IDLE && (is_out || is_nop)) begin
                  state_nxt = T1;
               end else begin
                  state_nxt = T5;
               end
            end
            T5: state_nxt = (SKIP_IDLE && is_lda) ? T1 : T6;
            T6: state_nxt = T1;
            default: state_nxt = T1;
         endcase
      end
   end

   assign t_state = state_p0;

   always_comb begin
      cp  = 1'b0;
      ep  = 1'b0;
      lm  = 1'b0;
      ce  = 1'b0;
      li  = 1'b0;
      ei  = 1'b0;
      la  = 1'b0;
      ea  = 1'b0;
      su  = 1'b0;
      eu  = 1'b0;
      lb  = 1'b0;
      lo  = 1'b0;
      hlt = 1'b0;
      if (!clr) begin
         if (halted_p0) begin
            hlt = 1'b1;
         end else begin
            case (state_p0)
               T1: begin
                  ep = 1'b1;
                  lm = 1'b1;
               end
               T2: cp = 1'b1;
               T3: begin
                  ce = 1'b1;
                  li = 1'b1;
               end
               T4: begin
                  if (is_lda || is_add || is_sub) begin
                     ei = 1'b1;
                     lm = 1'b1;
                  end else if (is_out) begin
                     ea = 1'b1;
                     lo = 1'b1;
                  end else if (is_hlt) begin
                     hlt = 1'b1;
                  end
               end
               T5: begin
                  if (is_lda) begin
                     ce = 1'b1;
                     la = 1'b1;
                  end else if (is_add || is_sub) begin
                     ce = 1'b1;
                     lb = 1'b1;
                  end
               end
               // B was loaded at the end of T5, so su/eu see a settled operand here
               T6: begin
                  if (is_add || is_sub) begin
                     eu = 1'b1;
                     la = 1'b1;
                     su = is_sub;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Bench for controlador_sequenciador: two instances (SKIP_IDLE 0 and 1) driven by scripted then random
// opcode streams; expected control words go into per-instance queues and a negedge monitor compares.
module tb_controlador_sequenciador;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] clr = 2'b11;
   logic [3:0] opc [2];
   logic [5:0] ts  [2];
   logic [1:0] cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

   controlador_sequenciador #(.SKIP_IDLE(1'b0)) u0 (
      .clk(clk), .clr(clr[0]), .opcode(opc[0]), .t_state(ts[0]),
      .cp(cp[0]), .ep(ep[0]), .lm(lm[0]), .ce(ce[0]), .li(li[0]), .ei(ei[0]), .la(la[0]),
      .ea(ea[0]), .su(su[0]), .eu(eu[0]), .lb(lb[0]), .lo(lo[0]), .hlt(hlt[0])
   );

   controlador_sequenciador #(.SKIP_IDLE(1'b1)) u1 (
      .clk(clk), .clr(clr[1]), .opcode(opc[1]), .t_state(ts[1]),
      .cp(cp[1]), .ep(ep[1]), .lm(lm[1]), .ce(ce[1]), .li(li[1]), .ei(ei[1]), .la(la[1]),
      .ea(ea[1]), .su(su[1]), .eu(eu[1]), .lb(lb[1]), .lo(lo[1]), .hlt(hlt[1])
   );

   localparam logic [12:0] M_CP  = 13'd1 << 12;
   localparam logic [12:0] M_EP  = 13'd1 << 11;
   localparam logic [12:0] M_LM  = 13'd1 << 10;
   localparam logic [12:0] M_CE  = 13'd1 << 9;
   localparam logic [12:0] M_LI  = 13'd1 << 8;
   localparam logic [12:0] M_EI  = 13'd1 << 7;
   localparam logic [12:0] M_LA  = 13'd1 << 6;
   localparam logic [12:0] M_EA  = 13'd1 << 5;
   localparam logic [12:0] M_SU  = 13'd1 << 4;
   localparam logic [12:0] M_EU  = 13'd1 << 3;
   localparam logic [12:0] M_LB  = 13'd1 << 2;
   localparam logic [12:0] M_LO  = 13'd1 << 1;
   localparam logic [12:0] M_HLT = 13'd1;
   localparam logic [12:0] M_BUS = M_EP | M_CE | M_EI | M_EA | M_EU;

   typedef struct {
      logic [5:0]  ts;
      logic [12:0] cw;
      bit          chk_ts;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int tests = 0;
   int fails = 0;

   // Reference model state: position within the current instruction (1..6), halt, knowledge of state
   int         step  [2] = '{1, 1};
   bit         hlt_m [2] = '{1'b0, 1'b0};
   int         hcnt  [2] = '{0, 0};
   bit         known [2] = '{1'b0, 1'b0};
   logic [3:0] prog0 [$] = '{4'd2, 4'd1, 4'd15, 4'd1};
   logic [3:0] prog1 [$] = '{4'd0, 4'd14, 4'd5, 4'd15};
   bit         mid_pending = 1'b0;

   // Microprogram table: signals asserted at each step of each instruction
   function automatic logic [12:0] exp_cw(input int s, input logic [3:0] op, input bit h, input bit c);
      logic [12:0] w;
      w = '0;
      if (c) return '0;
      if (h) return M_HLT;
      case (s)
         1: w = M_EP | M_LM;
         2: w = M_CP;
         3: w = M_CE | M_LI;
         4: begin
            if (op == 4'd0 || op == 4'd1 || op == 4'd2) w = M_EI | M_LM;
            else if (op == 4'd14) w = M_EA | M_LO;
            else if (op == 4'd15) w = M_HLT;
         end
         5: begin
            if (op == 4'd0) w = M_CE | M_LA;
            else if (op == 4'd1 || op == 4'd2) w = M_CE | M_LB;
         end
         6: begin
            if (op == 4'd1) w = M_EU | M_LA;
            else if (op == 4'd2) w = M_SU | M_EU | M_LA;
         end
         default: ;
      endcase
      return w;
   endfunction

   // Number of T-states an instruction occupies
   function automatic int instr_len(input logic [3:0] op, input bit skip);
      if (!skip) return 6;
      if (op == 4'd0) return 5;
      if (op == 4'd14) return 4;
      if (op == 4'd1 || op == 4'd2 || op == 4'd15) return 6;
      return 4;
   endfunction

   task automatic drive_cycle(input bit force_clr);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         bit c;
         bit rand_phase;
         logic [3:0] o;
         exp_t e;
         o = opc[d];
         c = force_clr;
         rand_phase = (d == 0) ? (prog0.size() == 0) : (prog1.size() == 0);
         if (!c) begin
            if (hlt_m[d] && hcnt[d] >= 10) begin
               c = 1'b1;
               if (d == 0) mid_pending = 1'b1;
            end else if (d == 0 && mid_pending && !hlt_m[0] && step[0] == 5 && o == 4'd1) begin
               c = 1'b1;
               mid_pending = 1'b0;
            end else if (rand_phase && !(d == 0 && mid_pending) && $urandom_range(0, 59) == 0) begin
               c = 1'b1;
            end
         end
         if (!c && !hlt_m[d] && step[d] == 1) begin
            if (d == 0 && prog0.size() > 0) o = prog0.pop_front();
            else if (d == 1 && prog1.size() > 0) o = prog1.pop_front();
            else o = 4'($urandom_range(0, 15));
         end
         if (hlt_m[d] && !c) o = 4'($urandom_range(0, 15));
         clr[d] = c;
         opc[d] = o;
         e.cw = exp_cw(step[d], o, hlt_m[d], c);
         e.ts = 6'(1 << (step[d] - 1));
         e.chk_ts = known[d];
         if (d == 0) sb0.push_back(e);
         else sb1.push_back(e);
         if (c) begin
            step[d] = 1;
            hlt_m[d] = 1'b0;
            hcnt[d] = 0;
            known[d] = 1'b1;
         end else if (hlt_m[d]) begin
            hcnt[d]++;
         end else if (step[d] == 4 && o == 4'd15) begin
            hlt_m[d] = 1'b1;
            hcnt[d] = 0;
         end else begin
            step[d] = (step[d] >= instr_len(o, d == 1)) ? 1 : step[d] + 1;
         end
      end
   endtask

   task automatic check(input int d, input exp_t e, input logic [12:0] a, input logic [5:0] t);
      tests++;
      if (a !== e.cw) begin
         fails++;
         $display("FAIL ctrl dut%0d @%0t: got %b want %b (cp ep lm ce li ei la ea su eu lb lo hlt)", d, $time, a, e.cw);
      end
      tests++;
      if ($countones(a & M_BUS) > 1) begin
         fails++;
         $display("FAIL bus_excl dut%0d @%0t: got %b want at most one bus driver", d, $time, a);
      end
      if (e.chk_ts) begin
         tests++;
         if (t !== e.ts) begin
            fails++;
            $display("FAIL t_state dut%0d @%0t: got %b want %b", d, $time, t, e.ts);
         end
         tests++;
         if (!$onehot(t)) begin
            fails++;
            $display("FAIL onehot dut%0d @%0t: got %b want one-hot", d, $time, t);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb0.size() > 0) begin
         e = sb0.pop_front();
         check(0, e, {cp[0], ep[0], lm[0], ce[0], li[0], ei[0], la[0], ea[0], su[0], eu[0], lb[0], lo[0], hlt[0]}, ts[0]);
      end
      if (sb1.size() > 0) begin
         e = sb1.pop_front();
         check(1, e, {cp[1], ep[1], lm[1], ce[1], li[1], ei[1], la[1], ea[1], su[1], eu[1], lb[1], lo[1], hlt[1]}, ts[1]);
      end
   end

   initial begin
      opc[0] = 4'd0;
      opc[1] = 4'd0;
      drive_cycle(1'b1);
      drive_cycle(1'b1);
      repeat (1500) drive_cycle(1'b0);
      @(negedge clk);
      #1;
      tests++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d/%0d pending want 0/0", sb0.size(), sb1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
